// File: rtl/multdiv_pkg.sv
// Shared constants and types for the multiply/divide unit.
package multdiv_pkg;

  // Operand/result width; only 32 is supported.
  localparam int unsigned WIDTH = 32;

  // Width of the divider's iteration counter.
  localparam int unsigned COUNT_W = $clog2(WIDTH);

  // Most negative operand; also used by the multiplier overflow check.
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module multdiv_div_step
  import multdiv_pkg::*;
(
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // One extra top bit so the difference's sign is always visible.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Shift, subtract, and restore when the trial difference goes negative.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {2'b00, divisor};
    if (!diff[WIDTH+1]) begin
      rem_out = diff[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multdiv_divider.sv
// Sequential signed divider: one quotient bit per clock, truncating toward zero.
// Divide-by-zero and INT_MIN / -1 are flagged on data_exception, not trapped.
module multdiv_divider
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [COUNT_W-1:0] LastCount = COUNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             exc_q, exc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exception_q, exception_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH:0]   abs_a;
  logic [WIDTH:0]   abs_b;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  multdiv_div_step u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Operand magnitudes, one bit wider so |INT_MIN| is representable.
  always_comb begin
    abs_a    = {data_operandA[WIDTH-1], data_operandA};
    abs_b    = {data_operandB[WIDTH-1], data_operandB};
    abs_a    = data_operandA[WIDTH-1] ? (~abs_a + 1'b1) : abs_a;
    abs_b    = data_operandB[WIDTH-1] ? (~abs_b + 1'b1) : abs_b;
    div_zero = (data_operandB == '0);
    overflow = (data_operandA == INT_MIN) && (data_operandB == '1);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a start pulse in any state restarts the operation.
  always_comb begin
    state_d = state_q;
    if (ctrl_DIV) begin
      state_d = div_zero ? DONE : BUSY;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        BUSY:    if (count_q == LastCount) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next-state: capture, iterate, or publish the result.
  always_comb begin
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    exc_d       = exc_q;
    result_d    = result_q;
    exception_d = exception_q;
    rdy_d       = 1'b0;
    if (ctrl_DIV) begin
      count_d   = '0;
      rem_d     = '0;
      // A zero quotient on divide-by-zero makes DONE publish 0 with no special case.
      quo_d     = div_zero ? '0 : abs_a[WIDTH-1:0];
      divisor_d = abs_b[WIDTH-1:0];
      sign_a_d  = data_operandA[WIDTH-1];
      sign_b_d  = data_operandB[WIDTH-1];
      exc_d     = div_zero | overflow;
    end else begin
      case (state_q)
        BUSY: begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + COUNT_W'(1);
        end
        DONE: begin
          result_d    = (sign_a_q ^ sign_b_q) ? (~quo_q + 1'b1) : quo_q;
          exception_d = exc_q;
          rdy_d       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      exc_q       <= 1'b0;
      result_q    <= '0;
      exception_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      exc_q       <= exc_d;
      result_q    <= result_d;
      exception_q <= exception_d;
      rdy_q       <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exception_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_divider.sv
// Bench for multdiv_divider: directed vector table, hand-written corner sequences,
// and random operands against an arithmetic reference model.
module tb_multdiv_divider;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_cmp = 0;
  int n_fail = 0;

  multdiv_divider dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endfunction

  // Reference: signed division truncating toward zero, with the two flagged cases.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic e);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (sb == 0) begin
      q = 32'h0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && sb == -1) begin
      q = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = sa / sb;
      e = 1'b0;
    end
  endfunction

  // Issue a start pulse on the next edge; operands are then scrambled to prove
  // they are only sampled on the capture edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Edges counted from the capture edge until data_resultRDY rises; 0 on timeout.
  task automatic wait_rdy(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic e, input int exp_lat);
    int lat;
    start_op(a, b);
    wait_rdy(lat);
    check({name, ".lat"}, 32'(lat), 32'(exp_lat));
    check({name, ".q"}, data_result, q);
    check({name, ".exc"}, {31'b0, data_exception}, {31'b0, e});
    @(posedge clock);
    #1;
    check({name, ".rdy_drop"}, {31'b0, data_resultRDY}, 32'h0);
    check({name, ".held"}, data_result, q);
  endtask

  initial begin
    int lat;
    logic [31:0] rq;
    logic        re;
    logic        seen;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         1'b0, 33};
    vecs[1]  = '{-32'sd100,      32'd7,          32'hFFFF_FFF2,  1'b0, 33};
    vecs[2]  = '{32'd7,          -32'sd100,      32'd0,          1'b0, 33};
    vecs[3]  = '{32'd12345,      32'd0,          32'd0,          1'b1, 1};
    vecs[4]  = '{32'd9,          32'd3,          32'd3,          1'b0, 33};
    vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 33};
    vecs[6]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 33};
    vecs[7]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 33};
    vecs[8]  = '{32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, 33};
    vecs[9]  = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 33};
    vecs[10] = '{32'd0,          32'd5,          32'd0,          1'b0, 33};
    vecs[11] = '{32'd5,          -32'sd5,        32'hFFFF_FFFF,  1'b0, 33};

    // Reset state.
    #12;
    check("reset.q", data_result, 32'h0);
    check("reset.exc", {31'b0, data_exception}, 32'h0);
    check("reset.rdy", {31'b0, data_resultRDY}, 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].exc,
                vecs[i].lat);
    end

    // Back-to-back: start on the edge that drops RDY, no bubble.
    start_op(32'd50, 32'd5);
    wait_rdy(lat);
    check("b2b.first.lat", 32'(lat), 32'd33);
    check("b2b.first.q", data_result, 32'd10);
    start_op(32'd81, 32'd9);
    wait_rdy(lat);
    check("b2b.second.lat", 32'(lat), 32'd33);
    check("b2b.second.q", data_result, 32'd9);
    @(posedge clock);
    #1;

    // Abort: restart at cycle 15, only one pulse counted from the second start.
    start_op(32'd1000, 32'd10);
    seen = 1'b0;
    repeat (14) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen = 1'b1;
    end
    start_op(-32'sd81, 32'd9);
    wait_rdy(lat);
    check("abort.no_early_rdy", {31'b0, seen}, 32'h0);
    check("abort.lat", 32'(lat), 32'd33);
    check("abort.q", data_result, 32'hFFFF_FFF7);
    check("abort.exc", {31'b0, data_exception}, 32'h0);
    @(posedge clock);
    #1;

    // Reset mid-operation clears outputs at once and suppresses the pulse.
    start_op(32'd777, 32'd7);
    repeat (19) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst.q", data_result, 32'h0);
    check("midrst.exc", {31'b0, data_exception}, 32'h0);
    check("midrst.rdy", {31'b0, data_resultRDY}, 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen = 1'b1;
    end
    check("midrst.no_rdy", {31'b0, seen}, 32'h0);
    run_check("postrst", 32'd9, 32'd3, 32'd3, 1'b0, 33);

    // Random operands; small divisors and zero are mixed in to hit the edges.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(0, 20)) - 32'd10;
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = {$urandom_range(0, 1) == 1 ? 32'hFFFF_FFF0 : 32'h0} | 32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      ref_div(a, b, rq, re);
      run_check($sformatf("rnd%0d", i), a, b, rq, re, (b == 32'h0) ? 1 : 33);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
